// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Stall/flush sequencer for the 5-stage pipeline: data-memory
//               wait FSM, load-use stall, IF/ID flush and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_useRt,
    input  logic [1:0]       id_PCsrc,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memRead,
    input  logic             mem_memWrite,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             dmem_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                  c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                r_halted;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_mem_acc;
    logic w_load_use;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_bubble;
    logic w_exmem_en, w_memwb_en, w_dmem_req;

    assign w_mem_acc  = mem_memRead | mem_memWrite;
    assign w_load_use = ex_memRead & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs) | (id_useRt & (ex_rd == id_rt)));

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pc_en        = 1'b0;
        w_ifid_en      = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_en     = 1'b0;
        w_memwb_en     = 1'b0;
        w_dmem_req     = 1'b0;

        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                w_dmem_req = (r_state == ST_MEM_WAIT) ? 1'b1 : w_mem_acc;
                if ((r_state == ST_RUN && w_mem_acc && !dmem_ack) ||
                    (r_state == ST_MEM_WAIT && !dmem_ack)) begin
                    // Memory stall: whole pipeline frozen.
                    if (r_state == ST_RUN) begin
                        w_state_nxt    = ST_MEM_WAIT;
                        w_wait_cnt_nxt = '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt    = ST_HALT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_idex_en   = 1'b1;
                    w_exmem_en  = 1'b1;
                    w_memwb_en  = 1'b1;
                    if (w_load_use) begin
                        // Redirect is deferred until the hazard clears.
                        w_idex_bubble = 1'b1;
                    end else begin
                        w_pc_en      = 1'b1;
                        w_ifid_en    = 1'b1;
                        w_ifid_flush = (id_PCsrc != 2'd0);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase

        if (rst) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_en     = 1'b0;
            w_idex_bubble = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_en    = 1'b0;
            w_dmem_req    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_halted   <= (w_state_nxt == ST_HALT);
            if (!w_pc_en && r_state != ST_HALT && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_ifid_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_en     = w_idex_en;
    assign idex_bubble = w_idex_bubble;
    assign exmem_en    = w_exmem_en;
    assign memwb_en    = w_memwb_en;
    assign dmem_req    = w_dmem_req;
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It takes decoded control from the ID and EX stages plus the data-memory handshake, and drives the per-stage register enables, bubble and flush controls. It owns three mechanisms: the multi-cycle data-memory wait FSM, load-use stall insertion, and IF/ID flush on taken branch/jump. It also provides saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 15, consecutive MEM_WAIT cycles without dmem_ack before entering HALT (must be >= 1).
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_useRt  in  1  ID instruction reads rt (R-type, sw, beq, bne)
id_PCsrc  in  2  PC select from ID control: 0 = seq, 1 = branch taken, 2 = jump
ex_memRead  in  1  instruction in EX is lw
ex_rd  in  5  destination register of the instruction in EX
mem_memRead  in  1  instruction in MEM reads data memory
mem_memWrite  in  1  instruction in MEM writes data memory
dmem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads NOP (takes precedence over hold)
idex_en  out  1  ID/EX register enable
idex_bubble  out  1  ID/EX loads all-zero control (valid only when idex_en=1)
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
dmem_req  out  1  data memory request
halted  out  1  pipeline halted on memory timeout
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT and reset, saturating
flush_cnt  out  CNT_W  cycles with ifid_flush=1, saturating

Behaviour:
- Clocking: single clock clk. Reset rst is synchronous and active-high.
- State: FSM {RUN, MEM_WAIT, HALT}, wait_cnt (ceil(log2(MEM_TIMEOUT+1)) bits), stall_cnt, flush_cnt.
- Registered outputs: halted, stall_cnt, flush_cnt.
- Combinational outputs: all other outputs decode from state and inputs.
- rst=1 at a clock edge: state=RUN, wait_cnt=0, counters=0, halted=0.
- While rst is high: every enable, ifid_flush, idex_bubble and dmem_req is forced to 0. This holds even if rst is asserted mid-wait.
- mem_acc = mem_memRead | mem_memWrite.
- load_use = ex_memRead & (ex_rd != 0) & ((ex_rd == id_rs) | (id_useRt & (ex_rd == id_rt))).
- Priority: HALT > memory stall > load-use > flush.
- HALT state:
  - All enables 0, flush/bubble 0, dmem_req 0, halted=1.
  - Counters frozen.
  - Only rst exits HALT.
- RUN state, dmem_req = mem_acc.
  - mem_acc & !dmem_ack (memory stall):
    - all five enables 0, flush/bubble 0.
    - next state MEM_WAIT, wait_cnt <= 0.
  - Otherwise, if load_use:
    - pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1, memwb_en=1.
    - id_PCsrc is ignored this cycle; it is re-evaluated once the stall clears.
  - Otherwise, if id_PCsrc != 0:
    - all enables 1, ifid_flush=1.
  - Otherwise:
    - all enables 1, no flush/bubble.
- MEM_WAIT state, dmem_req=1 (held until ack).
  - dmem_ack=1:
    - this cycle behaves exactly as RUN with ack present: load-use and flush rules apply.
    - next state RUN.
  - dmem_ack=0:
    - all enables 0.
    - If wait_cnt == MEM_TIMEOUT-1, next state HALT; otherwise wait_cnt++.
  - Total unacked request cycles before HALT = 1 (in RUN) + MEM_TIMEOUT.
- stall_cnt increments when pc_en=0, state != HALT and rst=0. It saturates at 2^CNT_W-1.
- flush_cnt increments when ifid_flush=1. It saturates at 2^CNT_W-1.
- Boundary cases:
  - An ack in the same cycle as the request causes zero stall.
  - A load-use with ex_rd=0 never stalls.
  - A lw in EX that also needs MEM wait produces a memory stall only; load-use is evaluated on the cycle the ack arrives.

Test Plan:
- Reset sequencing: drive rst=1 for 2 cycles with mem_memRead=1, then rst=0 with dmem_ack=1 -> during reset all enables=0, dmem_req=0, counters=0; afterwards all enables=1 and dmem_req=1.
- Load-use stall: ex_memRead=1, ex_rd=8, id_rs=8 -> for 1 cycle pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1, stall_cnt=1. With ex_rd=0 instead -> no stall.
- Load-use vs branch: load_use together with id_PCsrc=1 -> stall cycle has ifid_flush=0. Next cycle (hazard gone, id_PCsrc=1) -> ifid_flush=1, flush_cnt=1.
- Memory wait: mem_memWrite=1, dmem_ack arrives 3 cycles after the request -> enables 0 for 3 cycles, dmem_req=1 for 4 cycles, release on the ack cycle, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_memRead=1, ack never arrives -> halted=1 after 5 request cycles, dmem_req=0 afterwards; a late ack is ignored; rst clears halted.
- Counter saturation: CNT_W=4, 20 consecutive flush cycles -> flush_cnt holds at 15.
